// File: rtl/two_to_four_decoder.sv
// Registered 2-to-4 line decoder with enable, plus one saturating hit counter
// per output line. All outputs come straight from flops.
module two_to_four_decoder #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             A,
    input  logic             B,
    output logic             D0,
    output logic             D1,
    output logic             D2,
    output logic             D3,
    output logic             valid,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1,
    output logic [CNT_W-1:0] cnt2,
    output logic [CNT_W-1:0] cnt3
);

    localparam logic [CNT_W-1:0] CntMax = '1;

    logic [3:0]       dec_d, dec_q;
    logic             valid_d, valid_q;
    logic [CNT_W-1:0] cnt_d [4];
    logic [CNT_W-1:0] cnt_q [4];
    logic [1:0]       sel;

    assign sel = {A, B};

    // One-hot decode of the select, gated by enable
    always_comb begin
        dec_d = 4'b0000;
        if (en) begin
            unique case (sel)
                2'b00:   dec_d = 4'b0001;
                2'b01:   dec_d = 4'b0010;
                2'b10:   dec_d = 4'b0100;
                default: dec_d = 4'b1000;
            endcase
        end
        valid_d = en;
    end

    // Counter next state: clear beats increment; increments stop at all-ones
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = cnt_q[i];
            if (clr) begin
                cnt_d[i] = '0;
            end else if (dec_d[i] && (cnt_q[i] != CntMax)) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // Decoded lines and valid flag, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dec_q   <= 4'b0000;
            valid_q <= 1'b0;
        end else begin
            dec_q   <= dec_d;
            valid_q <= valid_d;
        end
    end

    // Hit counters, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign D0    = dec_q[0];
    assign D1    = dec_q[1];
    assign D2    = dec_q[2];
    assign D3    = dec_q[3];
    assign valid = valid_q;
    assign cnt0  = cnt_q[0];
    assign cnt1  = cnt_q[1];
    assign cnt2  = cnt_q[2];
    assign cnt3  = cnt_q[3];

endmodule

// File: tb/tb_two_to_four_decoder.sv
// Directed bench for two_to_four_decoder: an 8-bit-counter instance checked
// against a small reference model, plus a 2-bit-counter instance for saturation.
module tb_two_to_four_decoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance (CNT_W = 8)
    logic       rst_n, en, clr, A, B;
    logic       D0, D1, D2, D3, valid;
    logic [7:0] cnt0, cnt1, cnt2, cnt3;

    // Saturation instance (CNT_W = 2)
    logic       s_rst_n, s_en, s_clr, s_A, s_B;
    logic       s_D0, s_D1, s_D2, s_D3, s_valid;
    logic [1:0] s_cnt0, s_cnt1, s_cnt2, s_cnt3;

    two_to_four_decoder #(.CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .A(A), .B(B),
        .D0(D0), .D1(D1), .D2(D2), .D3(D3), .valid(valid),
        .cnt0(cnt0), .cnt1(cnt1), .cnt2(cnt2), .cnt3(cnt3)
    );

    two_to_four_decoder #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(s_rst_n), .en(s_en), .clr(s_clr), .A(s_A), .B(s_B),
        .D0(s_D0), .D1(s_D1), .D2(s_D2), .D3(s_D3), .valid(s_valid),
        .cnt0(s_cnt0), .cnt1(s_cnt1), .cnt2(s_cnt2), .cnt3(s_cnt3)
    );

    int n_checks = 0;
    int n_errs   = 0;

    // Reference model state for the main instance
    logic [3:0] exp_d;
    logic       exp_valid;
    int         exp_cnt [4];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance the model using the inputs that will be sampled at the next edge
    task automatic model_edge();
        if (!rst_n) begin
            exp_d     = 4'b0000;
            exp_valid = 1'b0;
            for (int i = 0; i < 4; i++) exp_cnt[i] = 0;
        end else begin
            exp_valid = en;
            exp_d     = en ? (4'b0001 << {A, B}) : 4'b0000;
            for (int i = 0; i < 4; i++) begin
                if (clr) exp_cnt[i] = 0;
                else if (exp_d[i] && exp_cnt[i] < 255) exp_cnt[i]++;
            end
        end
    endtask

    task automatic check_model(input string tag);
        check_eq({tag, ".d"}, {28'd0, D3, D2, D1, D0}, {28'd0, exp_d});
        check_eq({tag, ".valid"}, {31'd0, valid}, {31'd0, exp_valid});
        check_eq({tag, ".cnt0"}, {24'd0, cnt0}, exp_cnt[0]);
        check_eq({tag, ".cnt1"}, {24'd0, cnt1}, exp_cnt[1]);
        check_eq({tag, ".cnt2"}, {24'd0, cnt2}, exp_cnt[2]);
        check_eq({tag, ".cnt3"}, {24'd0, cnt3}, exp_cnt[3]);
        check_eq({tag, ".onehot"}, 32'(D0) + 32'(D1) + 32'(D2) + 32'(D3), {31'd0, exp_valid});
    endtask

    // One clock: update model, wait for the edge, sample 1 time unit later
    task automatic tick(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_model(tag);
    endtask

    task automatic set_sel(input logic a, input logic b);
        A = a;
        B = b;
    endtask

    initial begin
        logic [1:0] sweep [4];
        logic [1:0] sat_exp [6];
        sweep   = '{2'b11, 2'b01, 2'b10, 2'b00};
        sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};

        rst_n = 1'b0; en = 1'b1; clr = 1'b0; A = 1'b1; B = 1'b1;
        s_rst_n = 1'b0; s_en = 1'b0; s_clr = 1'b0; s_A = 1'b0; s_B = 1'b0;
        #2;

        // Reset held two cycles with en=1, {A,B}=11
        tick("rst0");
        tick("rst1");
        check_eq("rst.d_hand", {28'd0, D3, D2, D1, D0}, 32'h0);
        check_eq("rst.cnt3_hand", {24'd0, cnt3}, 32'd0);

        // Release: first edge decodes 11
        rst_n = 1'b1;
        tick("rel");
        check_eq("rel.d3_hand", {31'd0, D3}, 32'd1);
        check_eq("rel.cnt3_hand", {24'd0, cnt3}, 32'd1);

        // Sweep all codes
        for (int i = 0; i < 4; i++) begin
            set_sel(sweep[i][1], sweep[i][0]);
            tick($sformatf("sweep%0d", i));
        end
        check_eq("sweep.cnt3_hand", {24'd0, cnt3}, 32'd2);
        check_eq("sweep.cnt0_hand", {24'd0, cnt0}, 32'd1);

        // Toggling pattern: A every 2 cycles, B every 3 cycles
        for (int i = 0; i < 50; i++) begin
            set_sel(1'((i / 2) % 2), 1'((i / 3) % 2));
            tick($sformatf("tog%0d", i));
        end

        // Enable low while cycling all codes
        en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_sel(1'(i >> 1), 1'(i));
            tick($sformatf("en_lo%0d", i));
            check_eq("en_lo.valid_hand", {31'd0, valid}, 32'd0);
        end
        en = 1'b1;
        set_sel(1'b0, 1'b1);
        tick("en_hi");
        check_eq("en_hi.d1_hand", {31'd0, D1}, 32'd1);

        // Clear vs increment: bring cnt2 to 5 from zero
        clr = 1'b1; en = 1'b0;
        tick("clr_all");
        clr = 1'b0; en = 1'b1;
        set_sel(1'b1, 1'b0);
        for (int i = 0; i < 5; i++) tick($sformatf("cnt2_up%0d", i));
        check_eq("cnt2_five_hand", {24'd0, cnt2}, 32'd5);
        clr = 1'b1;
        tick("clr_inc");
        check_eq("clr_inc.cnt2_hand", {24'd0, cnt2}, 32'd0);
        check_eq("clr_inc.d_hand", {28'd0, D3, D2, D1, D0}, 32'h4);
        check_eq("clr_inc.valid_hand", {31'd0, valid}, 32'd1);
        clr = 1'b0;
        tick("after_clr");
        check_eq("after_clr.cnt2_hand", {24'd0, cnt2}, 32'd1);

        // Reset mid-operation after 10 decoded cycles
        for (int i = 0; i < 10; i++) begin
            set_sel(1'(i % 2), 1'(i % 3 == 0));
            tick($sformatf("pre_rst%0d", i));
        end
        rst_n = 1'b0;
        tick("mid_rst");
        check_eq("mid_rst.cnt_hand", {cnt0, cnt1, cnt2, cnt3}, 32'd0);
        check_eq("mid_rst.valid_hand", {31'd0, valid}, 32'd0);
        rst_n = 1'b1;
        set_sel(1'b0, 1'b0);
        tick("post_rst");
        check_eq("post_rst.cnt0_hand", {24'd0, cnt0}, 32'd1);

        // Saturation on the 2-bit instance (reset applied since time 0)
        s_rst_n = 1'b1; s_en = 1'b1; s_A = 1'b0; s_B = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            check_eq($sformatf("sat%0d.cnt1", i), {30'd0, s_cnt1}, {30'd0, sat_exp[i]});
            check_eq($sformatf("sat%0d.others", i), {26'd0, s_cnt0, s_cnt2, s_cnt3}, 32'd0);
            check_eq($sformatf("sat%0d.d1", i), {28'd0, s_D3, s_D2, s_D1, s_D0}, 32'h2);
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
